rf_write_arbiter: RTL and testbench

//   Shares the register file's single write port between two writeback requesters
//   (req0 = ALU result, req1 = memory load data) with round-robin arbitration.

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_write_arbiter_if.sv | 44 ++++
 rtl/rf_pend_scoreboard.sv | 69 ++++++
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 tb/tb_rf_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter slice.
//   RF_DATA_W / RF_ADDR_W / RF_PEND_W : default widths for data, register address
//                                        and per-register pending counters.
//   RF_NREG                            : number of architectural registers.
//   rf_addr_t / rf_data_t / pend_cnt_t : convenience types at the default widths.
//   rr_sel_e                           : round-robin pointer encoding (which requester
//                                        wins when both are valid).
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_PEND_W = 2;
  localparam int RF_NREG   = 1 << RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_PEND_W-1:0] pend_cnt_t;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two writeback sources and the register file.
//   req0_*  : ALU writeback request (valid/addr/data in, ready back)
//   req1_*  : load writeback request (valid/addr/data in, ready back)
//   rf_*    : register file write port (we/waddr/wdata)
// Handshake: a request transfers on a cycle where both valid and ready are high.
// ready is a same-cycle grant and is never high without its valid; valid may be
// dropped or changed freely while ready is low.
// Modports:
//   master : writeback sources + register file view (drive requests, see ready/rf_*)
//   slave  : the arbiter (sees requests, drives ready and the rf_* write port)
interface rf_write_arbiter_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_pend_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register counting
// writes that decode has reserved but the register file has not yet received.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   claim_valid/addr      : decode reserves a destination register
//   claim_ready           : reservation accepted (counter not saturated; always 1 for r0)
//   clr_en/clr_addr       : register file write happening this cycle (retires one pending)
//   chk_addr1/2           : source registers to hazard-check
//   chk_busy1/2           : corresponding register has >=1 pending write
//   busy_vec              : per-register pending flag; bit 0 is always 0
module rf_pend_scoreboard #(
  parameter int ADDR_W = rf_pkg::RF_ADDR_W,
  parameter int PEND_W = rf_pkg::RF_PEND_W,
  parameter int NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_ready,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic [NREG-1:0]   busy_vec
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] cnt [NREG];
  logic [NREG-1:0]   incVec;
  logic [NREG-1:0]   decVec;
  logic              claimHit;

  // Register 0 is hard-wired: it always accepts a claim and never counts.
  assign claim_ready = (claim_addr == '0) || (cnt[claim_addr] != PEND_MAX);
  assign claimHit    = claim_valid && claim_ready && (claim_addr != '0);

  always_comb begin
    incVec = '0;
    decVec = '0;
    if (claimHit) incVec[claim_addr] = 1'b1;
    // A retire against an empty counter is dropped rather than wrapping.
    if (clr_en && (cnt[clr_addr] != '0)) decVec[clr_addr] = 1'b1;
  end

  // Claim and retire on the same register cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (incVec[i] && !decVec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (decVec[i] && !incVec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NREG; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign chk_busy1 = busy_vec[chk_addr1];
  assign chk_busy2 = busy_vec[chk_addr2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the ALU writeback
// (req0) and load writeback (req1) with round-robin arbitration, and keeps
// a pending-write scoreboard for the decode stage.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb (slave modport)    : req0/req1 valid/addr/data/ready, rf_we/rf_waddr/rf_wdata
//   claim_valid/addr      : decode reserves a destination register
//   claim_ready           : reservation accepted
//   chk_addr1/2           : source registers to hazard-check
//   chk_busy1/2           : register has >=1 pending write
//   busy_vec              : per-register pending flags
//   rr_dbg                : current round-robin pointer (who wins a tie)
// The write port is registered: a grant in cycle N shows up as rf_we in N+1.
// A write to r0 is granted (the request is consumed) but never reaches the RF.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int PEND_W = RF_PEND_W,
  parameter int NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_write_arbiter_if.slave wb,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_ready,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic [NREG-1:0]   busy_vec,
  output rr_sel_e           rr_dbg
);

  rr_sel_e           rrPtr;
  rr_sel_e           rrNext;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;
  logic              winWrite;

  logic              rfWe;
  logic [ADDR_W-1:0] rfWaddr;
  logic [DATA_W-1:0] rfWdata;

  // Arbitration and pointer update. A lone request always wins; on a tie the
  // pointer picks, and whoever wins hands priority to the other side.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    rrNext = rrPtr;
    if (wb.req0_valid && (!wb.req1_valid || (rrPtr == RR_REQ0))) grant0 = 1'b1;
    else if (wb.req1_valid) grant1 = 1'b1;
    if (grant0) rrNext = RR_REQ1;
    else if (grant1) rrNext = RR_REQ0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr <= RR_REQ0;
    else rrPtr <= rrNext;
  end

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;
  assign rr_dbg        = rrPtr;

  assign winAddr  = grant1 ? wb.req1_addr : wb.req0_addr;
  assign winData  = grant1 ? wb.req1_data : wb.req0_data;
  assign winWrite = (grant0 || grant1) && (winAddr != '0);

  // Address/data hold their last written values whenever no write goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfWdata <= '0;
    end else begin
      rfWe <= winWrite;
      if (winWrite) begin
        rfWaddr <= winAddr;
        rfWdata <= winData;
      end
    end
  end

  assign wb.rf_we    = rfWe;
  assign wb.rf_waddr = rfWaddr;
  assign wb.rf_wdata = rfWdata;

  // The registered write retires its pending entry on the same edge the RF
  // captures the data.
  rf_pend_scoreboard #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W),
    .NREG   (NREG)
  ) u_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .clr_en      (rfWe),
    .clr_addr    (rfWaddr),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int AW   = RF_ADDR_W;
  localparam int DW   = RF_DATA_W;
  localparam int NR   = RF_NREG;
  localparam int PMAX = (1 << RF_PEND_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  logic          claim_valid = 1'b0;
  logic [AW-1:0] claim_addr  = '0;
  logic [AW-1:0] chk_addr1   = '0;
  logic [AW-1:0] chk_addr2   = '0;
  logic          claim_ready;
  logic          chk_busy1;
  logic          chk_busy2;
  logic [NR-1:0] busy_vec;
  rr_sel_e       rr_dbg;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PEND_W(RF_PEND_W), .NREG(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ready (claim_ready),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .busy_vec    (busy_vec),
    .rr_dbg      (rr_dbg)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending counts per register, the last issued write, and who is favoured on a tie.
  int                 mcnt [NR];
  bit                 mwe    = 1'b0;
  logic [AW-1:0]      mwaddr = '0;
  logic [DW-1:0]      mwdata = '0;
  bit                 mfav1  = 1'b0;
  logic [AW+DW-1:0]   exp_q[$];

  function automatic bit exp_g0();
    return wb.req0_valid && (!wb.req1_valid || !mfav1);
  endfunction

  function automatic bit exp_g1();
    return wb.req1_valid && !exp_g0();
  endfunction

  function automatic bit exp_claim_ready();
    return (claim_addr == 0) || (mcnt[claim_addr] < PMAX);
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (mcnt[i] > 0);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) mcnt[i] = 0;
      mwe = 1'b0; mwaddr = '0; mwdata = '0; mfav1 = 1'b0;
      exp_q.delete();
    end else begin
      bit g0, g1, inc, dec;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      g0  = exp_g0();
      g1  = exp_g1();
      inc = claim_valid && (claim_addr != 0) && (mcnt[claim_addr] < PMAX);
      dec = mwe && (mcnt[mwaddr] > 0);
      if (!(inc && dec && (claim_addr == mwaddr))) begin
        if (inc) mcnt[claim_addr]++;
        if (dec) mcnt[mwaddr]--;
      end
      mwe = 1'b0;
      if (g0 || g1) begin
        a = g0 ? wb.req0_addr : wb.req1_addr;
        d = g0 ? wb.req0_data : wb.req1_data;
        mfav1 = g0;
        if (a != 0) begin
          mwe = 1'b1; mwaddr = a; mwdata = d;
          exp_q.push_back({a, d});
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("rf_we",       wb.rf_we,      mwe);
      check("rf_waddr",    wb.rf_waddr,   mwaddr);
      check("rf_wdata",    wb.rf_wdata,   mwdata);
      check("req0_ready",  wb.req0_ready, exp_g0());
      check("req1_ready",  wb.req1_ready, exp_g1());
      check("rr_ptr",      rr_dbg,        mfav1);
      check("claim_ready", claim_ready,   exp_claim_ready());
      check("chk_busy1",   chk_busy1,     mcnt[chk_addr1] > 0);
      check("chk_busy2",   chk_busy2,     mcnt[chk_addr2] > 0);
      check("busy_vec",    busy_vec,      exp_busy());
      if (wb.rf_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_stream: got write %0h:%0h expected none", wb.rf_waddr, wb.rf_wdata);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("wr_stream", {wb.rf_waddr, wb.rf_wdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.req0_valid = v; wb.req0_addr = a; wb.req0_data = d;
  endtask

  task automatic drive_req1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.req1_valid = v; wb.req1_addr = a; wb.req1_data = d;
  endtask

  task automatic idle_reqs();
    drive_req0(1'b0, '0, '0);
    drive_req1(1'b0, '0, '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_reqs();
    claim_valid = 1'b0; claim_addr = 7;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we",       wb.rf_we,    0);
    check("rst_rf_waddr",    wb.rf_waddr, 0);
    check("rst_rf_wdata",    wb.rf_wdata, 0);
    check("rst_busy_vec",    busy_vec,    0);
    check("rst_claim_ready", claim_ready, 1);
    check("rst_rr",          rr_dbg,      RR_REQ0);
    rst_n = 1'b1;

    // Single ALU write to r3.
    drive_req0(1'b1, 3, 32'h11);
    #1;
    check("t1_req0_ready", wb.req0_ready, 1);
    check("t1_req1_ready", wb.req1_ready, 0);
    tick();
    idle_reqs();
    check("t1_rf_we",    wb.rf_we,    1);
    check("t1_rf_waddr", wb.rf_waddr, 3);
    check("t1_rf_wdata", wb.rf_wdata, 32'h11);
    tick();
    check("t1_idle_we",    wb.rf_we,    0);
    check("t1_hold_waddr", wb.rf_waddr, 3);

    // Load to r0: consumed, never written.
    drive_req1(1'b1, 0, 32'hFF);
    #1;
    check("t3_req1_ready", wb.req1_ready, 1);
    check("t3_req0_ready", wb.req0_ready, 0);
    tick();
    idle_reqs();
    check("t3_rf_we",    wb.rf_we,    0);
    check("t3_busy_vec", busy_vec,    0);
    check("t3_waddr",    wb.rf_waddr, 3);

    // Both valid for four cycles: grants alternate starting with req0.
    for (int k = 0; k < 4; k++) begin
      drive_req0(1'b1, 5, 32'hA0 + k);
      drive_req1(1'b1, 6, 32'hB0 + k);
      #1;
      check("t2_req0_ready", wb.req0_ready, (k % 2) == 0);
      check("t2_req1_ready", wb.req1_ready, (k % 2) == 1);
      tick();
      check("t2_rf_we",    wb.rf_we,    1);
      check("t2_rf_waddr", wb.rf_waddr, ((k % 2) == 0) ? 5 : 6);
      check("t2_rf_wdata", wb.rf_wdata, ((k % 2) == 0) ? (32'hA0 + k) : (32'hB0 + k));
    end
    idle_reqs();
    tick();
    check("t2_end_we", wb.rf_we, 0);

    // Saturate r7 with three claims; the fourth is refused.
    claim_addr = 7;
    for (int k = 0; k < 3; k++) begin
      claim_valid = 1'b1;
      #1;
      check("t4_claim_ready", claim_ready, 1);
      tick();
    end
    #1;
    check("t4_claim4_ready", claim_ready, 0);
    check("t4_busy7",        busy_vec[7], 1);
    tick();
    claim_valid = 1'b0;
    check("t4_model_cnt7", mcnt[7], 3);
    drive_req0(1'b1, 7, 32'h77);
    tick();
    idle_reqs();
    check("t4_rf_we7", wb.rf_we, 1);
    tick();
    chk_addr1 = 7;
    #1;
    check("t4_claim_ready_after", claim_ready, 1);
    check("t4_chk_busy1",         chk_busy1,   1);
    check("t4_model_cnt7_after",  mcnt[7],     2);

    // Claim r9 on the same edge as a write retires r9: count stays 1.
    claim_valid = 1'b1; claim_addr = 9;
    tick();
    claim_valid = 1'b0;
    drive_req0(1'b1, 9, 32'h99);
    tick();
    idle_reqs();
    claim_valid = 1'b1; claim_addr = 9;
    #1;
    check("t5_rf_we9",       wb.rf_we,    1);
    check("t5_claim_ready",  claim_ready, 1);
    tick();
    claim_valid = 1'b0;
    chk_addr2 = 9;
    #1;
    check("t5_busy9",       busy_vec[9], 1);
    check("t5_chk_busy2",   chk_busy2,   1);
    check("t5_model_cnt9",  mcnt[9],     1);
    drive_req0(1'b1, 9, 32'h9A);
    tick();
    idle_reqs();
    tick();
    #1;
    check("t5_busy9_clear", busy_vec[9], 0);
    check("t5_model_cnt9_0", mcnt[9],    0);

    // Reset while a write to r12 is on the port.
    drive_req0(1'b1, 12, 32'h5A);
    tick();
    idle_reqs();
    #1;
    check("t6_pre_we", wb.rf_we, 1);
    claim_addr = 7;
    rst_n = 1'b0;
    #1;
    check("t6_rst_we",          wb.rf_we,    0);
    check("t6_rst_busy_vec",    busy_vec,    0);
    check("t6_rst_claim_ready", claim_ready, 1);
    check("t6_rst_rr",          rr_dbg,      RR_REQ0);
    tick();
    rst_n = 1'b1;
    drive_req0(1'b1, 1, 32'h1);
    drive_req1(1'b1, 2, 32'h2);
    #1;
    check("t6_post_req0_ready", wb.req0_ready, 1);
    tick();
    idle_reqs();
    repeat (3) tick();

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
